// File: rtl/whackamole_pkg.sv
// -----------------------------------------------------------------------------
// whackamole_pkg
// Shared types and constants for the whack-a-mole game sequencer:
//   state_t           - game FSM states
//   LFSR_W / LFSR_TAPS - 8-bit Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1
//   DEFAULT_NUM_MOLES - default number of mole buttons/LEDs
// -----------------------------------------------------------------------------
package whackamole_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        UP,
        COOLDOWN,
        OVER
    } state_t;

    localparam int LFSR_W = 8;

    // Tap mask over the register bits [7:0]: exponents 8,6,5,4 map to bits 7,5,4,3.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    localparam int DEFAULT_NUM_MOLES = 5;

endpackage

// File: rtl/whackamole_game_ctrl_lfsr.sv
// -----------------------------------------------------------------------------
// mole_lfsr
// 8-bit Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1) with a step enable.
// Maximal length: a non-zero seed never reaches the all-zero state.
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-high; loads SEED
//   en     - advance one step this cycle
//   state  - current LFSR register contents
// -----------------------------------------------------------------------------
module mole_lfsr
    import whackamole_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] lfsr_reg;
    logic [LFSR_W-1:0] lfsr_next;

    // Shift toward the MSB; the XOR of the tapped bits enters at bit 0.
    assign lfsr_next[0] = ^(lfsr_reg & LFSR_TAPS);

    generate
        for (genvar gi = 1; gi < LFSR_W; gi++) begin : g_shift
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_reg <= SEED;
        end else if (en) begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign state = lfsr_reg;

endmodule

// File: rtl/whackamole_game_ctrl.sv
// -----------------------------------------------------------------------------
// whackamole_game_ctrl
// Game sequencer: picks moles pseudo-randomly, drives one-hot mole LEDs,
// times each mole and the whole round (in 1 Hz ticks) and keeps score.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   tick          - one-cycle 1 Hz enable
//   start_pulse   - one-cycle start request (ignored while playing)
//   mole_btn      - debounced button levels, active-high
//   mole_led      - one-hot mole LED or zero
//   score, misses - hits / timed-out moles this round (saturating)
//   time_left     - remaining round ticks
//   playing       - high in SPAWN, UP, COOLDOWN
//   game_over     - high in OVER
// Build option: define WRONG_PENALTY_EN to make a wrong-button press in UP
// cost one point (floor 0) and retire the current mole.
// -----------------------------------------------------------------------------
module whackamole_game_ctrl
    import whackamole_pkg::*;
#(
    parameter int                NUM_MOLES    = DEFAULT_NUM_MOLES,
    parameter int                GAME_SECONDS = 30,
    parameter int                MOLE_TICKS   = 2,
    parameter int                SCORE_W      = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 8'hA5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 start_pulse,
    input  logic [NUM_MOLES-1:0] mole_btn,
    output logic [NUM_MOLES-1:0] mole_led,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   misses,
    output logic [7:0]           time_left,
    output logic                 playing,
    output logic                 game_over
);

    localparam int IDX_W = $clog2(NUM_MOLES);
    localparam int MT_W  = $clog2(MOLE_TICKS + 1);

    state_t               state_reg, state_next;
    logic [NUM_MOLES-1:0] btn_q_reg;
    logic [NUM_MOLES-1:0] btn_rise;
    logic [NUM_MOLES-1:0] mole_led_reg, mole_led_next;
    logic [IDX_W-1:0]     prev_idx_reg, prev_idx_next;
    logic [MT_W-1:0]      mole_timer_reg, mole_timer_next;
    logic [SCORE_W-1:0]   score_reg, score_next;
    logic [SCORE_W-1:0]   misses_reg, misses_next;
    logic [7:0]           time_left_reg, time_left_next;
    logic                 playing_reg, game_over_reg;

    logic [LFSR_W-1:0]    lfsr_val;
    logic [IDX_W-1:0]     idx_raw, idx_pick;
    logic                 round_active, round_end, hit;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .en    (1'b1),
        .state (lfsr_val)
    );

    // A button counts only on the cycle it goes high.
    assign btn_rise = mole_btn & ~btn_q_reg;
    assign hit      = |(btn_rise & mole_led_reg);

    // Never show the same mole twice in a row: bump a repeat to the next slot.
    assign idx_raw  = IDX_W'(lfsr_val % LFSR_W'(NUM_MOLES));
    assign idx_pick = (idx_raw != prev_idx_reg)                  ? idx_raw :
                      (idx_raw == IDX_W'(NUM_MOLES - 1))         ? '0      :
                                                                   idx_raw + IDX_W'(1);

    assign round_active = (state_reg == SPAWN) || (state_reg == UP) || (state_reg == COOLDOWN);
    assign round_end    = round_active && tick && (time_left_reg == 8'd1);

`ifdef WRONG_PENALTY_EN
    logic wrong;
    assign wrong = |(btn_rise & ~mole_led_reg);
`endif

    always_comb begin
        state_next      = state_reg;
        mole_led_next   = mole_led_reg;
        prev_idx_next   = prev_idx_reg;
        mole_timer_next = mole_timer_reg;
        score_next      = score_reg;
        misses_next     = misses_reg;
        time_left_next  = time_left_reg;

        case (state_reg)
            IDLE, OVER: begin
                if (start_pulse) begin
                    state_next     = SPAWN;
                    score_next     = '0;
                    misses_next    = '0;
                    time_left_next = 8'(GAME_SECONDS);
                    mole_led_next  = '0;
                end
            end
            SPAWN: begin
                mole_led_next   = NUM_MOLES'(1) << idx_pick;
                prev_idx_next   = idx_pick;
                mole_timer_next = MT_W'(MOLE_TICKS);
                state_next      = UP;
            end
            UP: begin
                if (hit) begin
                    if (score_reg != '1) score_next = score_reg + SCORE_W'(1);
                    mole_led_next = '0;
                    state_next    = COOLDOWN;
`ifdef WRONG_PENALTY_EN
                end else if (wrong) begin
                    if (score_reg != '0) score_next = score_reg - SCORE_W'(1);
                    mole_led_next = '0;
                    state_next    = COOLDOWN;
`endif
                end else if (tick && (mole_timer_reg == MT_W'(1))) begin
                    // The final round tick swallows a simultaneous miss.
                    if (!round_end && (misses_reg != '1)) misses_next = misses_reg + SCORE_W'(1);
                    mole_led_next = '0;
                    state_next    = COOLDOWN;
                end else if (tick) begin
                    mole_timer_next = mole_timer_reg - MT_W'(1);
                end
            end
            COOLDOWN: begin
                mole_led_next = '0;
                if (tick) state_next = SPAWN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Round timer runs under every in-round state and wins over the
        // per-state transitions above.
        if (round_active && tick && (time_left_reg != 8'd0)) begin
            time_left_next = time_left_reg - 8'd1;
        end
        if (round_end) begin
            mole_led_next = '0;
            state_next    = OVER;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            btn_q_reg      <= '0;
            mole_led_reg   <= '0;
            prev_idx_reg   <= '0;
            mole_timer_reg <= '0;
            score_reg      <= '0;
            misses_reg     <= '0;
            time_left_reg  <= '0;
            playing_reg    <= 1'b0;
            game_over_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            btn_q_reg      <= mole_btn;
            mole_led_reg   <= mole_led_next;
            prev_idx_reg   <= prev_idx_next;
            mole_timer_reg <= mole_timer_next;
            score_reg      <= score_next;
            misses_reg     <= misses_next;
            time_left_reg  <= time_left_next;
            playing_reg    <= (state_next == SPAWN) || (state_next == UP) || (state_next == COOLDOWN);
            game_over_reg  <= (state_next == OVER);
        end
    end

    assign mole_led  = mole_led_reg;
    assign score     = score_reg;
    assign misses    = misses_reg;
    assign time_left = time_left_reg;
    assign playing   = playing_reg;
    assign game_over = game_over_reg;

endmodule

// File: tb/tb_whackamole_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_whackamole_game_ctrl
// Directed bench for whackamole_game_ctrl. Three instances share clock, reset
// and tick; each has its own start and buttons:
//   a: defaults (30 s round, 2-tick moles, 8-bit score)
//   b: 3-tick round, for round-end behaviour and the wrong-button case
//   c: 200-tick round, 2-bit score, for 100 spawns and saturation
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_whackamole_game_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;

    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [4:0] btn_a = '0, btn_b = '0, btn_c = '0;
    logic [4:0] led_a, led_b, led_c;
    logic [7:0] score_a, misses_a, tl_a, score_b, misses_b, tl_b, tl_c;
    logic [1:0] score_c, misses_c;
    logic       play_a, over_a, play_b, over_b, play_c, over_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    whackamole_game_ctrl dut_a (
        .clock(clock), .reset(reset), .tick(tick), .start_pulse(start_a),
        .mole_btn(btn_a), .mole_led(led_a), .score(score_a), .misses(misses_a),
        .time_left(tl_a), .playing(play_a), .game_over(over_a)
    );

    whackamole_game_ctrl #(.GAME_SECONDS(3)) dut_b (
        .clock(clock), .reset(reset), .tick(tick), .start_pulse(start_b),
        .mole_btn(btn_b), .mole_led(led_b), .score(score_b), .misses(misses_b),
        .time_left(tl_b), .playing(play_b), .game_over(over_b)
    );

    whackamole_game_ctrl #(.GAME_SECONDS(200), .SCORE_W(2)) dut_c (
        .clock(clock), .reset(reset), .tick(tick), .start_pulse(start_c),
        .mole_btn(btn_c), .mole_led(led_c), .score(score_c), .misses(misses_c),
        .time_left(tl_c), .playing(play_c), .game_over(over_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Index of the single set bit, or -1 when not exactly one-hot.
    function automatic int onehot_idx(input logic [4:0] v);
        int idx = -1;
        int cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (v[i]) begin
                idx = i;
                cnt++;
            end
        end
        return (cnt == 1) ? idx : -1;
    endfunction

    // Called at a falling edge; the tick is seen by exactly one rising edge.
    task automatic tick_once();
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
    endtask

    int k, m, prev, w;

    initial begin
        // ---------------- reset with tick and buttons active ----------------
        tick  = 1'b1;
        btn_a = '1;
        btn_b = '1;
        btn_c = '1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        tick  = 1'b0;
        btn_a = '0;
        btn_b = '0;
        btn_c = '0;
        check("rst_led", 32'(led_a), 32'h0);
        check("rst_score", 32'(score_a), 32'h0);
        check("rst_misses", 32'(misses_a), 32'h0);
        check("rst_time", 32'(tl_a), 32'h0);
        check("rst_playing", 32'(play_a), 32'h0);
        check("rst_over", 32'(over_a), 32'h0);
        tick_once();
        tick_once();
        check("idle_time", 32'(tl_a), 32'h0);
        check("idle_playing", 32'(play_a), 32'h0);
        check("idle_led", 32'(led_a), 32'h0);

        // ---------------- a: start, hit, held button ----------------
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        check("a_start_playing", 32'(play_a), 32'h1);
        check("a_start_time", 32'(tl_a), 32'd30);
        check("a_spawn_led0", 32'(led_a), 32'h0);
        @(negedge clock);
        k = onehot_idx(led_a);
        check("a_up_onehot", 32'(k >= 0), 32'h1);
        if (k < 0) k = 0;
        btn_a = 5'(1) << k;
        @(negedge clock);
        check("a_hit_score", 32'(score_a), 32'h1);
        check("a_hit_led", 32'(led_a), 32'h0);
        repeat (50) @(negedge clock);
        check("a_held_score", 32'(score_a), 32'h1);
        btn_a = '0;
        @(negedge clock);

        // ---------------- a: mole timeout ----------------
        tick_once();
        check("a_tick_time", 32'(tl_a), 32'd29);
        @(negedge clock);
        m = onehot_idx(led_a);
        check("a_up2_onehot", 32'(m >= 0), 32'h1);
        check("a_up2_differs", 32'(m != k), 32'h1);
        if (m < 0) m = 0;
        tick_once();
        check("a_tick1_led", 32'(led_a), 32'(5'(1) << m));
        check("a_tick1_misses", 32'(misses_a), 32'h0);
        tick_once();
        check("a_timeout_led", 32'(led_a), 32'h0);
        check("a_timeout_misses", 32'(misses_a), 32'h1);
        check("a_timeout_time", 32'(tl_a), 32'd27);

        // ---------------- a: hit together with mole-timeout tick ----------------
        tick_once();
        @(negedge clock);
        m = onehot_idx(led_a);
        check("a_up3_onehot", 32'(m >= 0), 32'h1);
        if (m < 0) m = 0;
        tick_once();
        tick  = 1'b1;
        btn_a = 5'(1) << m;
        @(negedge clock);
        tick  = 1'b0;
        btn_a = '0;
        check("a_hit_tmo_score", 32'(score_a), 32'h2);
        check("a_hit_tmo_misses", 32'(misses_a), 32'h1);
        check("a_hit_tmo_led", 32'(led_a), 32'h0);
        check("a_hit_tmo_time", 32'(tl_a), 32'd24);

        // ---------------- b round 1: game over on 3rd tick ----------------
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        check("b1_time", 32'(tl_b), 32'd3);
        @(negedge clock);
        tick_once();
        tick_once();
        check("b1_misses", 32'(misses_b), 32'h1);
        check("b1_time1", 32'(tl_b), 32'd1);
        check("b1_not_over", 32'(over_b), 32'h0);
        tick_once();
        check("b1_over", 32'(over_b), 32'h1);
        check("b1_playing", 32'(play_b), 32'h0);
        check("b1_time0", 32'(tl_b), 32'h0);
        check("b1_led", 32'(led_b), 32'h0);
        check("b1_misses_held", 32'(misses_b), 32'h1);

        // ---------------- b round 2: hit on the final tick ----------------
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        check("b2_score_clr", 32'(score_b), 32'h0);
        check("b2_misses_clr", 32'(misses_b), 32'h0);
        check("b2_over_clr", 32'(over_b), 32'h0);
        tick_once();                       // tick lands in SPAWN
        k = onehot_idx(led_b);
        check("b2_time2", 32'(tl_b), 32'd2);
        check("b2_onehot", 32'(k >= 0), 32'h1);
        if (k < 0) k = 0;
        tick_once();
        check("b2_time1", 32'(tl_b), 32'd1);
        tick  = 1'b1;
        btn_b = 5'(1) << k;
        @(negedge clock);
        tick  = 1'b0;
        btn_b = '0;
        check("b2_final_score", 32'(score_b), 32'h1);
        check("b2_final_misses", 32'(misses_b), 32'h0);
        check("b2_final_over", 32'(over_b), 32'h1);
        check("b2_final_led", 32'(led_b), 32'h0);
        check("b2_final_time", 32'(tl_b), 32'h0);
        btn_b = '1;
        repeat (3) @(negedge clock);
        btn_b = '0;
        @(negedge clock);
        check("b2_over_press_score", 32'(score_b), 32'h1);
        check("b2_over_press_over", 32'(over_b), 32'h1);

        // ---------------- b round 3: wrong button at score 0 ----------------
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        check("b3_score_clr", 32'(score_b), 32'h0);
        @(negedge clock);
        k = onehot_idx(led_b);
        check("b3_onehot", 32'(k >= 0), 32'h1);
        if (k < 0) k = 0;
        btn_b = 5'(1) << ((k + 1) % 5);
        @(negedge clock);
        btn_b = '0;
        check("b3_wrong_score", 32'(score_b), 32'h0);
`ifdef WRONG_PENALTY_EN
        check("b3_wrong_led", 32'(led_b), 32'h0);
`else
        check("b3_wrong_led", 32'(led_b), 32'(5'(1) << k));
`endif

        // ---------------- c: 100 spawns, saturation ----------------
        start_c = 1'b1;
        @(negedge clock);
        start_c = 1'b0;
        prev = -1;
        for (int i = 0; i < 100; i++) begin
            w = 0;
            while (led_c == '0 && w < 10) begin
                @(negedge clock);
                w++;
            end
            m = onehot_idx(led_c);
            check($sformatf("c_onehot_%0d", i), 32'(m >= 0), 32'h1);
            if (i > 0) check($sformatf("c_differs_%0d", i), 32'(m != prev), 32'h1);
            if (m < 0) m = 0;
            prev = m;
            btn_c = 5'(1) << m;
            @(negedge clock);
            btn_c = '0;
            if (i == 1) check("c_score2", 32'(score_c), 32'h2);
            if (i == 4) check("c_score_sat", 32'(score_c), 32'h3);
            tick_once();
        end
        check("c_final_score", 32'(score_c), 32'h3);
        check("c_final_misses", 32'(misses_c), 32'h0);
        check("c_final_time", 32'(tl_c), 32'd100);
        check("c_playing", 32'(play_c), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
